// File: rtl/mem_access_controller.sv
// Data-memory access stage: runs one single-port SRAM cycle (SETUP/STROBE/RECOVER)
// per load/store request and stalls the pipeline while the access is in flight.
module mem_access_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memControl,
  input  logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_data_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int WC = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW = (WC > 1) ? $clog2(WC) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETUP   = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [CW-1:0]     r_count;
  logic [ADDR_W-1:0] r_ramAddr;
  logic [DATA_W-1:0] r_ramWdata;
  logic [DATA_W-1:0] r_readData;
  logic              r_done;

  logic w_request;
  logic w_active;
  logic w_strobe;
  logic w_isWrite;

  assign w_request = (memControl == OP_WRITE) || (memControl == OP_READ);
  assign w_active  = (r_state != S_IDLE);
  assign w_strobe  = (r_state == S_STROBE);
  assign w_isWrite = (r_op == OP_WRITE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= 2'b00;
      r_count    <= '0;
      r_ramAddr  <= '1;
      r_ramWdata <= '0;
      r_readData <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_request) begin
            r_op      <= memControl;
            r_ramAddr <= memAddr;
            if (memControl == OP_WRITE) r_ramWdata <= writeData;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_count <= CW'(WC - 1);
        end
        S_STROBE: begin
          // Load data is captured on the last strobe edge, while oe_n is still low.
          if (r_count != '0) begin
            r_count <= r_count - CW'(1);
          end else begin
            r_state <= S_RECOVER;
            if (r_op == OP_READ) r_readData <= ram_rdata;
          end
        end
        S_RECOVER: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so oe_n and we_n can never overlap.
  assign ram_ce_n    = !w_active;
  assign ram_oe_n    = !(w_strobe && (r_op == OP_READ));
  assign ram_we_n    = !(w_strobe && w_isWrite);
  assign ram_data_oe = w_active && w_isWrite;
  assign ram_addr    = r_ramAddr;
  assign ram_wdata   = r_ramWdata;
  assign readData    = r_readData;
  assign done        = r_done;
  assign busy        = rst && (w_active || w_request);

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: one WAIT_CYCLES=1 instance and one
// WAIT_CYCLES=3 instance, load data tracked through an expected-value queue.
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ramRdata;

  logic [1:0]  memControl1, memControl3;
  logic [15:0] memAddr1, memAddr3, writeData1, writeData3;
  logic [15:0] readData1, readData3, ramAddr1, ramAddr3, ramWdata1, ramWdata3;
  logic        busy1, busy3, done1, done3, dataOe1, dataOe3;
  logic        ceN1, ceN3, oeN1, oeN3, weN1, weN3;

  int nCompared = 0;
  int nMismatched = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  mem_access_controller #(.WAIT_CYCLES(1), .DATA_W(16), .ADDR_W(16)) dut1 (
    .clk(clk), .rst(rst), .memControl(memControl1), .memAddr(memAddr1),
    .writeData(writeData1), .readData(readData1), .busy(busy1), .done(done1),
    .ram_addr(ramAddr1), .ram_wdata(ramWdata1), .ram_rdata(ramRdata),
    .ram_data_oe(dataOe1), .ram_ce_n(ceN1), .ram_oe_n(oeN1), .ram_we_n(weN1)
  );

  mem_access_controller #(.WAIT_CYCLES(3), .DATA_W(16), .ADDR_W(16)) dut3 (
    .clk(clk), .rst(rst), .memControl(memControl3), .memAddr(memAddr3),
    .writeData(writeData3), .readData(readData3), .busy(busy3), .done(done3),
    .ram_addr(ramAddr3), .ram_wdata(ramWdata3), .ram_rdata(ramRdata),
    .ram_data_oe(dataOe3), .ram_ce_n(ceN3), .ram_oe_n(oeN3), .ram_we_n(weN3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pops the oldest expected load value and compares it with the DUT output.
  task automatic popCheck(input string tag, input logic [15:0] observed);
    logic [15:0] exp;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=<empty queue>", tag, observed);
    end else begin
      exp = expQ.pop_front();
      checkOutput(tag, {16'h0, observed}, {16'h0, exp});
    end
  endtask

  task automatic strobes1(input string tag, input logic ce, input logic oe, input logic we);
    checkOutput({tag, "_ce_n"}, {31'h0, ceN1}, {31'h0, ce});
    checkOutput({tag, "_oe_n"}, {31'h0, oeN1}, {31'h0, oe});
    checkOutput({tag, "_we_n"}, {31'h0, weN1}, {31'h0, we});
  endtask

  // Ticks until done1 is seen or the budget expires; returns ticks taken.
  task automatic waitDone1(input string tag, input int maxCycles, output int n);
    n = 0;
    while (n < maxCycles) begin
      tick();
      n++;
      if (done1) return;
    end
    checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  task automatic applyStimulus(input logic [1:0] ctl, input logic [15:0] addr,
                               input logic [15:0] wdata);
    memControl1 = ctl;
    memAddr1    = addr;
    writeData1  = wdata;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    ramRdata = 16'h0;
    applyStimulus(2'b10, 16'h5555, 16'h0);
    memControl3 = 2'b10; memAddr3 = 16'h5555; writeData3 = 16'h0;

    // Reset held with a pending read
    tick();
    tick();
    strobes1("rst", 1'b1, 1'b1, 1'b1);
    checkOutput("rst_data_oe", {31'h0, dataOe1}, 32'h0);
    checkOutput("rst_addr", {16'h0, ramAddr1}, 32'hFFFF);
    checkOutput("rst_readData", {16'h0, readData1}, 32'h0);
    checkOutput("rst_wdata", {16'h0, ramWdata1}, 32'h0);
    checkOutput("rst_done", {31'h0, done1}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy1}, 32'h0);
    checkOutput("rst_busy3", {31'h0, busy3}, 32'h0);
    applyStimulus(2'b00, 16'hFFFF, 16'h0);
    memControl3 = 2'b00; memAddr3 = 16'hFFFF;
    rst = 1'b1;
    tick();
    checkOutput("idle_busy", {31'h0, busy1}, 32'h0);

    // Read 0x1234, WAIT_CYCLES=1
    applyStimulus(2'b10, 16'h1234, 16'h0);
    ramRdata = 16'hBEEF;
    #1 checkOutput("rd_req_busy", {31'h0, busy1}, 32'h1);
    expQ.push_back(16'hBEEF);
    tick();
    applyStimulus(2'b00, 16'h9999, 16'h0);
    strobes1("rd_c1", 1'b0, 1'b1, 1'b1);
    checkOutput("rd_c1_addr", {16'h0, ramAddr1}, 32'h1234);
    checkOutput("rd_c1_busy", {31'h0, busy1}, 32'h1);
    tick();
    strobes1("rd_c2", 1'b0, 1'b0, 1'b1);
    checkOutput("rd_c2_addr", {16'h0, ramAddr1}, 32'h1234);
    tick();
    ramRdata = 16'h0000;
    strobes1("rd_c3", 1'b0, 1'b1, 1'b1);
    checkOutput("rd_c3_busy", {31'h0, busy1}, 32'h1);
    checkOutput("rd_c3_done", {31'h0, done1}, 32'h0);
    tick();
    checkOutput("rd_done", {31'h0, done1}, 32'h1);
    checkOutput("rd_done_busy", {31'h0, busy1}, 32'h0);
    strobes1("rd_c4", 1'b1, 1'b1, 1'b1);
    popCheck("rd_readData", readData1);
    tick();
    checkOutput("rd_done_pulse", {31'h0, done1}, 32'h0);

    // Write 0xA5A5 to 0x0040, store data changed after accept
    applyStimulus(2'b01, 16'h0040, 16'hA5A5);
    tick();
    applyStimulus(2'b00, 16'hFFFF, 16'h0000);
    strobes1("wr_c1", 1'b0, 1'b1, 1'b1);
    checkOutput("wr_c1_wdata", {16'h0, ramWdata1}, 32'hA5A5);
    checkOutput("wr_c1_oe", {31'h0, dataOe1}, 32'h1);
    checkOutput("wr_c1_addr", {16'h0, ramAddr1}, 32'h0040);
    tick();
    strobes1("wr_c2", 1'b0, 1'b1, 1'b0);
    checkOutput("wr_c2_wdata", {16'h0, ramWdata1}, 32'hA5A5);
    checkOutput("wr_c2_oe", {31'h0, dataOe1}, 32'h1);
    tick();
    strobes1("wr_c3", 1'b0, 1'b1, 1'b1);
    checkOutput("wr_c3_wdata", {16'h0, ramWdata1}, 32'hA5A5);
    checkOutput("wr_c3_oe", {31'h0, dataOe1}, 32'h1);
    tick();
    checkOutput("wr_done", {31'h0, done1}, 32'h1);
    checkOutput("wr_readData", {16'h0, readData1}, 32'hBEEF);
    checkOutput("wr_c4_oe", {31'h0, dataOe1}, 32'h0);
    tick();

    // Read 0x0100 on the WAIT_CYCLES=3 instance
    memControl3 = 2'b10; memAddr3 = 16'h0100;
    expQ.push_back(16'hC0DE);
    tick();
    memControl3 = 2'b00;
    checkOutput("w3_c1_oe_n", {31'h0, oeN3}, 32'h1);
    checkOutput("w3_c1_addr", {16'h0, ramAddr3}, 32'h0100);
    for (int c = 2; c <= 4; c++) begin
      ramRdata = (c == 4) ? 16'hC0DE : 16'hC000 + 16'(c);
      tick();
      checkOutput($sformatf("w3_c%0d_oe_n", c), {31'h0, oeN3}, 32'h0);
      checkOutput($sformatf("w3_c%0d_we_n", c), {31'h0, weN3}, 32'h1);
      checkOutput($sformatf("w3_c%0d_done", c), {31'h0, done3}, 32'h0);
    end
    tick();
    ramRdata = 16'hDEAD;
    checkOutput("w3_c5_oe_n", {31'h0, oeN3}, 32'h1);
    checkOutput("w3_c5_ce_n", {31'h0, ceN3}, 32'h0);
    checkOutput("w3_c5_done", {31'h0, done3}, 32'h0);
    tick();
    checkOutput("w3_done", {31'h0, done3}, 32'h1);
    popCheck("w3_readData", readData3);

    // Back-to-back: write 0x0010 then read 0x0010 offered in the done cycle
    applyStimulus(2'b01, 16'h0010, 16'h5A5A);
    tick();
    applyStimulus(2'b00, 16'hFFFF, 16'h0);
    waitDone1("b2b_wr", 10, n);
    checkOutput("b2b_wr_latency", n, 32'd3);
    applyStimulus(2'b10, 16'h0010, 16'h0);
    ramRdata = 16'h77AA;
    expQ.push_back(16'h77AA);
    #1 checkOutput("b2b_req_busy", {31'h0, busy1}, 32'h1);
    tick();
    applyStimulus(2'b00, 16'hFFFF, 16'h0);
    checkOutput("b2b_rd_c1_ce_n", {31'h0, ceN1}, 32'h0);
    checkOutput("b2b_rd_c1_addr", {16'h0, ramAddr1}, 32'h0010);
    checkOutput("b2b_rd_c1_data_oe", {31'h0, dataOe1}, 32'h0);
    waitDone1("b2b_rd", 10, n);
    checkOutput("b2b_gap", n + 1, 32'd4);
    popCheck("b2b_readData", readData1);

    // Reserved code 11 is ignored
    applyStimulus(2'b11, 16'h2222, 16'h0);
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput($sformatf("rsv%0d_busy", c), {31'h0, busy1}, 32'h0);
      tick();
      strobes1($sformatf("rsv%0d", c), 1'b1, 1'b1, 1'b1);
    end
    applyStimulus(2'b00, 16'hFFFF, 16'h0);
    tick();

    // Reset during STROBE aborts the read silently
    applyStimulus(2'b10, 16'h0200, 16'h0);
    ramRdata = 16'h9999;
    tick();
    applyStimulus(2'b00, 16'hFFFF, 16'h0);
    tick();
    checkOutput("abort_in_strobe", {31'h0, oeN1}, 32'h0);
    rst = 1'b0;
    tick();
    strobes1("abort", 1'b1, 1'b1, 1'b1);
    checkOutput("abort_done", {31'h0, done1}, 32'h0);
    checkOutput("abort_readData", {16'h0, readData1}, 32'h0);
    checkOutput("abort_busy", {31'h0, busy1}, 32'h0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("abort_nodone%0d", c), {31'h0, done1}, 32'h0);
    end

    // Fresh read after reset release
    applyStimulus(2'b10, 16'h0300, 16'h0);
    ramRdata = 16'h4321;
    expQ.push_back(16'h4321);
    tick();
    applyStimulus(2'b00, 16'hFFFF, 16'h0);
    waitDone1("fresh", 10, n);
    checkOutput("fresh_latency", n, 32'd3);
    popCheck("fresh_readData", readData1);
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
Data-memory access stage that sits directly downstream of the memory address calculator. It takes the registered memControl/memAddr pair plus the store data, and runs a multi-cycle single-port external SRAM cycle with ce/oe/we sequencing. It returns load data to writeback and raises a stall while an access is in flight. There is one access at a time and no buffering beyond the captured request.

Parameters:
WAIT_CYCLES, 1, number of cycles the oe_n/we_n strobe is held low; values below 1 are treated as 1.
DATA_W, 16, data bus width.
ADDR_W, 16, address bus width.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-low.
memControl  input  2  request code: 00 none, 01 write, 10 read, 11 reserved (ignored).
memAddr  input  ADDR_W  access address; 16'hFFFF when idle.
writeData  input  DATA_W  store data; sampled only on accept of a write.
readData  output  DATA_W  load data; updated only on completion of a read.
busy  output  1  pipeline stall request.
done  output  1  one-cycle pulse when an access completes.
ram_addr  output  ADDR_W  SRAM address.
ram_wdata  output  DATA_W  SRAM write data; the top level drives the tri-state buffer.
ram_rdata  input  DATA_W  SRAM read data.
ram_data_oe  output  1  enables the ram_wdata driver onto the shared bus.
ram_ce_n  output  1  SRAM chip enable, active-low.
ram_oe_n  output  1  SRAM output enable, active-low.
ram_we_n  output  1  SRAM write enable, active-low.

Behaviour:
- States: IDLE, SETUP, STROBE, RECOVER. A 2-bit captured op register and a wait counter sized for WAIT_CYCLES.
- Reset: at any rising edge with rst=0, regardless of state:
  - state goes to IDLE.
  - ram_ce_n=ram_oe_n=ram_we_n=1, ram_data_oe=0.
  - ram_addr=16'hFFFF, ram_wdata=0, readData=0, done=0.
  - busy is forced 0 while rst=0.
  - An access interrupted this way produces no done pulse and does not update readData.
- IDLE:
  - Strobes are deasserted and ram_data_oe=0; ram_addr holds its last value.
  - If memControl is 01 or 10 at the edge, capture op, memAddr and writeData (writes only), and go to SETUP.
  - memControl 00 or 11 leaves state unchanged.
- SETUP (1 cycle):
  - ram_addr = captured address, ram_ce_n=0, strobes high.
  - For writes, ram_wdata = captured data and ram_data_oe=1.
  - Next edge: go to STROBE and load the counter with WAIT_CYCLES-1.
- STROBE:
  - ram_ce_n=0.
  - Reads: ram_oe_n=0. Writes: ram_we_n=0 and ram_data_oe=1.
  - While the counter is nonzero, decrement it each edge.
  - On the edge where the counter is 0, go to RECOVER; for reads, also register readData <= ram_rdata on that edge.
- RECOVER (1 cycle):
  - Strobes high, ram_ce_n=0, address held; writes keep ram_data_oe=1 and ram_wdata for hold time.
  - Next edge: go to IDLE and set done=1.
- done is high for exactly the one cycle following RECOVER, then returns to 0.
- Latency, accept edge E0:
  - done is high after edge E0+WAIT_CYCLES+2.
  - With WAIT_CYCLES=1: SETUP after E0, STROBE after E1, RECOVER after E2, done after E3.
- busy is combinational:
  - 1 when state != IDLE.
  - 1 in IDLE when memControl is 01 or 10 (stall asserts in the request's own cycle).
  - Otherwise 0.
- Upstream holds its request while busy=1.
- A request present in the IDLE cycle where done=1 is a new access and is accepted (back-to-back, no bubble). Upstream must have advanced its request by then.
- Inputs are ignored outside IDLE; changes to memAddr, memControl or writeData mid-access have no effect.
- ram_we_n and ram_oe_n are never low in the same cycle; neither is ever low while ram_ce_n=1.
- Address 16'hFFFF is a normal address when requested. No address decode, no fault signalling.

Test Plan:
1. Reset: hold rst=0 for 2 edges with memControl=10 → ce_n/oe_n/we_n=1, ram_data_oe=0, ram_addr=16'hFFFF, readData=0, done=0, busy=0.
2. Read, WAIT_CYCLES=1: memControl=10, memAddr=16'h1234, ram_rdata=16'hBEEF → ram_addr=16'h1234 and ce_n=0 for cycles 1-3, oe_n=0 in cycle 2 only, we_n stays 1; done=1 and readData=16'hBEEF after E3; busy high from request cycle through RECOVER.
3. Write: memControl=01, memAddr=16'h0040, writeData=16'hA5A5, changed to 16'h0000 after E0 → ram_wdata=16'hA5A5 with ram_data_oe=1 for cycles 1-3, we_n=0 in cycle 2 only, oe_n stays 1, readData unchanged.
4. WAIT_CYCLES=3 read at 16'h0100 → oe_n low for exactly 3 consecutive cycles, done after E5, readData equals the ram_rdata value sampled at E4.
5. Back-to-back and ignored codes:
   - Write 16'h0010, then read 16'h0010 presented in the done cycle → read accepted immediately, second done 4 cycles after the first.
   - memControl=11 → no strobe activity, busy=0.
6. Reset mid-access: read started, rst=0 at the edge during STROBE → next cycle all strobes and ce_n high, IDLE, no done pulse, readData=0. After release, a fresh read completes normally.
